// File: rtl/polynomial_encoder.sv
`default_nettype none
// ============================================================================
// Module   : polynomial_encoder
// Purpose  : Reads 4 coefficients per group, reduces mod Q, packs to 7 bytes.
// Revision : 1.0
// ============================================================================
module polynomial_encoder #(
   parameter int Q       = 12289,
   parameter int NGROUPS = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [8:0]  poly_addr,
   input  logic [15:0] poly_do,
   output logic        byte_we,
   output logic [9:0]  byte_addr,
   output logic [7:0]  byte_di
);

   typedef enum logic [3:0] {
      S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_CAP,
      S_WR0, S_WR1, S_WR2, S_WR3, S_WR4, S_WR5, S_WR6, S_DONE
   } state_t;

   localparam logic [15:0] C_Q    = 16'(Q);
   localparam logic [6:0]  C_LAST = 7'(NGROUPS - 1);

   state_t      r_state;
   logic [6:0]  r_g;
   logic [13:0] r_c0, r_c1, r_c2, r_c3;

   logic        w_ge;
   logic [13:0] w_red;
   logic [9:0]  w_base;

   // Inputs lie in [0, 2Q-1], so one conditional subtract completes the reduction.
   assign w_ge   = (poly_do >= C_Q);
   assign w_red  = 14'(w_ge ? (poly_do - C_Q) : poly_do);
   assign w_base = {r_g, 3'b000} - {3'b000, r_g};

   // Outputs are loaded with the value belonging to the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_g       <= '0;
         r_c0      <= '0;
         r_c1      <= '0;
         r_c2      <= '0;
         r_c3      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         poly_addr <= '0;
         byte_we   <= 1'b0;
         byte_addr <= '0;
         byte_di   <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state   <= S_RD0;
                  r_g       <= '0;
                  busy      <= 1'b1;
                  poly_addr <= '0;
               end
            end
            S_RD0: begin
               r_state   <= S_RD1;
               poly_addr <= {r_g, 2'd1};
            end
            S_RD1: begin
               r_state   <= S_RD2;
               r_c0      <= w_red;
               poly_addr <= {r_g, 2'd2};
            end
            S_RD2: begin
               r_state   <= S_RD3;
               r_c1      <= w_red;
               poly_addr <= {r_g, 2'd3};
            end
            S_RD3: begin
               r_state   <= S_CAP;
               r_c2      <= w_red;
               poly_addr <= '0;
            end
            S_CAP: begin
               r_state   <= S_WR0;
               r_c3      <= w_red;
               byte_we   <= 1'b1;
               byte_addr <= w_base;
               byte_di   <= r_c0[7:0];
            end
            S_WR0: begin
               r_state   <= S_WR1;
               byte_addr <= byte_addr + 10'd1;
               byte_di   <= {r_c1[1:0], r_c0[13:8]};
            end
            S_WR1: begin
               r_state   <= S_WR2;
               byte_addr <= byte_addr + 10'd1;
               byte_di   <= r_c1[9:2];
            end
            S_WR2: begin
               r_state   <= S_WR3;
               byte_addr <= byte_addr + 10'd1;
               byte_di   <= {r_c2[3:0], r_c1[13:10]};
            end
            S_WR3: begin
               r_state   <= S_WR4;
               byte_addr <= byte_addr + 10'd1;
               byte_di   <= r_c2[11:4];
            end
            S_WR4: begin
               r_state   <= S_WR5;
               byte_addr <= byte_addr + 10'd1;
               byte_di   <= {r_c3[5:0], r_c2[13:12]};
            end
            S_WR5: begin
               r_state   <= S_WR6;
               byte_addr <= byte_addr + 10'd1;
               byte_di   <= r_c3[13:6];
            end
            S_WR6: begin
               byte_we   <= 1'b0;
               byte_addr <= '0;
               byte_di   <= '0;
               if (r_g == C_LAST) begin
                  r_state <= S_DONE;
                  done    <= 1'b1;
               end else begin
                  r_state   <= S_RD0;
                  r_g       <= r_g + 7'd1;
                  poly_addr <= {r_g + 7'd1, 2'd0};
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_g     <= '0;
               done    <= 1'b0;
               busy    <= 1'b0;
            end
            default: begin
               r_state   <= S_IDLE;
               r_g       <= '0;
               busy      <= 1'b0;
               done      <= 1'b0;
               poly_addr <= '0;
               byte_we   <= 1'b0;
               byte_addr <= '0;
               byte_di   <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
